// File: rtl/interp_pkg.sv
// interp_pkg: shared FSM states, Q15 constants and mux select encodings for interp_ramp_seq.
package interp_pkg;
  typedef enum logic [1:0] {IDLE, STEP, BASE, RUN} state_t;
  localparam int INV6_Q15 = 5461;
  localparam int NUM_SC = 12;
  localparam int PILOT_SPACING = 6;
  localparam int ROUND_Q15 = 16384;
  localparam logic [1:0] SEL_EST1 = 2'b00;
  localparam logic [1:0] SEL_INT = 2'b01;
  localparam logic [1:0] SEL_EST2 = 2'b10;
  localparam logic [1:0] SEL_EXT = 2'b11;
endpackage

// File: rtl/interp_step_calc.sv
// interp_step_calc: combinational rounded (est2 - est1) / 6 for one component.
module interp_step_calc
  import interp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] est1,
  input  logic signed [WIDTH-1:0] est2,
  output logic signed [WIDTH:0]   step
);
  logic signed [WIDTH:0] delta;
  logic signed [WIDTH+15:0] prod;
  always_comb begin
    delta = (WIDTH+1)'(est2) - (WIDTH+1)'(est1);
    prod = (WIDTH+16)'(delta) * (WIDTH+16)'(INV6_Q15) + (WIDTH+16)'(ROUND_Q15);
    step = (WIDTH+1)'(prod >>> 15);
  end
endmodule

// File: rtl/interp_ramp_seq.sv
// interp_ramp_seq: walks 12 subcarriers emitting a linear ramp through two pilot estimates plus mux select.
module interp_ramp_seq
  import interp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              nshift,
  input  logic signed [WIDTH-1:0] est1_re,
  input  logic signed [WIDTH-1:0] est1_im,
  input  logic signed [WIDTH-1:0] est2_re,
  input  logic signed [WIDTH-1:0] est2_im,
  output logic                    busy,
  output logic                    err,
  output logic                    out_valid,
  output logic [3:0]              sc_idx,
  output logic [1:0]              sel,
  output logic signed [WIDTH-1:0] ramp_re,
  output logic signed [WIDTH-1:0] ramp_im,
  output logic                    done
);
  localparam int AW = WIDTH + GUARD;
  localparam logic signed [AW-1:0] SMAX = AW'(2**(WIDTH-1) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
    return v > SMAX ? SMAX[WIDTH-1:0] : v < SMIN ? SMIN[WIDTH-1:0] : v[WIDTH-1:0];
  endfunction

  function automatic logic [1:0] sel_of(input logic [3:0] k, input logic [2:0] p);
    logic [3:0] a, b;
    a = {1'b0, p};
    b = a + 4'(PILOT_SPACING);
    return k == a ? SEL_EST1 : k == b ? SEL_EST2 : (k > a && k < b) ? SEL_INT : SEL_EXT;
  endfunction

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [2:0] k1;
  logic signed [WIDTH-1:0] e1_re, e1_im, e2_re, e2_im;
  logic signed [WIDTH:0] step_re, step_im, sr_d, si_d;
  logic signed [AW-1:0] acc_re, acc_im, ar_d, ai_d;

  interp_step_calc #(.WIDTH(WIDTH)) u_step_re (.est1(e1_re), .est2(e2_re), .step(sr_d));
  interp_step_calc #(.WIDTH(WIDTH)) u_step_im (.est1(e1_im), .est2(e2_im), .step(si_d));

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start && nshift <= 3'd5) state_d = STEP;
      STEP: state_d = k1 == 3'd0 ? RUN : BASE;
      BASE: if (cnt == {1'b0, k1} - 4'd1) state_d = RUN;
      RUN:  if (cnt == 4'(NUM_SC - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state ? 4'd0 : cnt + 4'd1;
    // STEP seeds est1, BASE walks left to k=0, RUN walks right across the PRB
    ar_d = state == STEP ? AW'(e1_re) : state == BASE ? acc_re - AW'(step_re) : acc_re + AW'(step_re);
    ai_d = state == STEP ? AW'(e1_im) : state == BASE ? acc_im - AW'(step_im) : acc_im + AW'(step_im);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      k1 <= '0;
      {e1_re, e1_im, e2_re, e2_im} <= '0;
      {step_re, step_im, acc_re, acc_im} <= '0;
      {busy, err, out_valid, done, sc_idx, sel, ramp_re, ramp_im} <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      acc_re <= ar_d;
      acc_im <= ai_d;
      busy <= state_d != IDLE;
      err <= state == IDLE && start && nshift > 3'd5;
      out_valid <= state_d == RUN;
      done <= state_d == RUN && cnt_d == 4'(NUM_SC - 1);
      sel <= state_d == RUN ? sel_of(cnt_d, k1) : SEL_EST1;
      if (state_d == RUN) begin
        sc_idx <= cnt_d;
        ramp_re <= sat(ar_d);
        ramp_im <= sat(ai_d);
      end
      if (state == IDLE && start) begin
        k1 <= nshift;
        {e1_re, e1_im, e2_re, e2_im} <= {est1_re, est1_im, est2_re, est2_im};
      end
      if (state == STEP) begin
        step_re <= sr_d;
        step_im <= si_d;
      end
    end
  end
endmodule

// File: tb/tb_interp_ramp_seq.sv
// tb_interp_ramp_seq: directed scenario tasks with hand-computed ramps, selects and latencies.
module tb_interp_ramp_seq;
  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] nshift;
  logic signed [15:0] est1_re, est1_im, est2_re, est2_im;
  logic busy, err, out_valid, done;
  logic [3:0] sc_idx;
  logic [1:0] sel;
  logic signed [15:0] ramp_re, ramp_im;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  interp_ramp_seq #(.WIDTH(16), .GUARD(4)) dut (
    .clk(clk), .rst(rst), .start(start), .nshift(nshift),
    .est1_re(est1_re), .est1_im(est1_im), .est2_re(est2_re), .est2_im(est2_im),
    .busy(busy), .err(err), .out_valid(out_valid), .sc_idx(sc_idx), .sel(sel),
    .ramp_re(ramp_re), .ramp_im(ramp_im), .done(done)
  );

  // Starts at a negedge, returns at the negedge of the STEP cycle.
  task automatic do_start(input int ns, input int a_re, input int a_im, input int b_re, input int b_im);
    nshift = 3'(ns);
    est1_re = 16'(a_re);
    est1_im = 16'(a_im);
    est2_re = 16'(b_re);
    est2_im = 16'(b_im);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    do_start(0, 0, 0, 0, 0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    n_chk++; if ({busy, err, out_valid, done, sc_idx, sel, ramp_re, ramp_im} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {busy, err, out_valid, done, sc_idx, sel, ramp_re, ramp_im}); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_ramp_re;
    logic [1:0] es [12] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    do_start(0, 4096, 0, 5632, 0);
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ramp_step_cycle: valid=%b busy=%b want 0/1", out_valid, busy); end
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      n_chk++; if (out_valid !== 1'b1 || sc_idx !== 4'(k)) begin n_fail++; $display("FAIL ramp_valid k=%0d: valid=%b idx=%0d", k, out_valid, sc_idx); end
      n_chk++; if (ramp_re !== 16'(4096 + 256 * k) || ramp_im !== 16'sd0) begin n_fail++; $display("FAIL ramp_value k=%0d: got %0d/%0d want %0d/0", k, ramp_re, ramp_im, 4096 + 256 * k); end
      n_chk++; if (sel !== es[k] || done !== (k == 11)) begin n_fail++; $display("FAIL ramp_sel k=%0d: sel=%b done=%b want %b/%b", k, sel, done, es[k], k == 11); end
      @(negedge clk);
    end
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0 || sel !== 2'b00 || done !== 1'b0) begin n_fail++; $display("FAIL ramp_after: busy=%b valid=%b sel=%b done=%b want all 0", busy, out_valid, sel, done); end
    n_chk++; if (ramp_re !== 16'sd6912 || sc_idx !== 4'd11) begin n_fail++; $display("FAIL ramp_hold: got %0d idx %0d want 6912 idx 11", ramp_re, sc_idx); end
  endtask

  task automatic test_neg_slope;
    logic [1:0] es [12] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
    do_start(3, 0, 0, -600, -600);
    for (int c = 1; c < 5; c++) begin
      n_chk++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL neg_latency c=%0d: valid=%b busy=%b want 0/1", c, out_valid, busy); end
      @(negedge clk);
    end
    for (int k = 0; k < 12; k++) begin
      n_chk++; if (out_valid !== 1'b1 || sc_idx !== 4'(k) || sel !== es[k]) begin n_fail++; $display("FAIL neg_sel k=%0d: valid=%b idx=%0d sel=%b want sel %b", k, out_valid, sc_idx, sel, es[k]); end
      n_chk++; if (ramp_re !== 16'(300 - 100 * k) || ramp_im !== 16'(300 - 100 * k)) begin n_fail++; $display("FAIL neg_value k=%0d: got %0d/%0d want %0d", k, ramp_re, ramp_im, 300 - 100 * k); end
      @(negedge clk);
    end
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL neg_end: busy=%b valid=%b want 0/0", busy, out_valid); end
  endtask

  task automatic test_saturation;
    int exp_v;
    do_start(0, 28672, 0, 32767, 0);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      exp_v = k <= 6 ? 28672 + 682 * k : 32767;
      n_chk++; if (out_valid !== 1'b1 || ramp_re !== 16'(exp_v)) begin n_fail++; $display("FAIL sat_value k=%0d: valid=%b got %0d want %0d", k, out_valid, ramp_re, exp_v); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal;
    logic seen;
    seen = 1'b0;
    do_start(6, 1000, 1000, 2000, 2000);
    n_chk++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL illegal_err: err=%b busy=%b want 1/0", err, busy); end
    @(negedge clk);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: err=%b want 0", err); end
    repeat (15) begin
      seen |= busy | out_valid;
      @(negedge clk);
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL illegal_quiet: busy/valid seen=%b want 0", seen); end
  endtask

  task automatic test_back_to_back;
    do_start(0, 4096, 0, 5632, 0);
    repeat (12) @(negedge clk);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
    do_start(0, 0, 0, 6000, 0);
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ignored: busy=%b valid=%b want 0/0", busy, out_valid); end
    do_start(2, 1000, 0, 1600, 0);
    for (int c = 1; c < 4; c++) begin
      n_chk++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_latency c=%0d: valid=%b busy=%b want 0/1", c, out_valid, busy); end
      @(negedge clk);
    end
    for (int k = 0; k < 12; k++) begin
      n_chk++; if (out_valid !== 1'b1 || ramp_re !== 16'(800 + 100 * k)) begin n_fail++; $display("FAIL b2b_value k=%0d: valid=%b got %0d want %0d", k, out_valid, ramp_re, 800 + 100 * k); end
      if (k == 2) begin n_chk++; if (sel !== 2'b00) begin n_fail++; $display("FAIL b2b_sel: got %b want 00", sel); end end
      @(negedge clk);
    end
  endtask

  task automatic test_midrun_reset;
    do_start(0, 4096, 0, 5632, 0);
    repeat (6) @(negedge clk);
    n_chk++; if (sc_idx !== 4'd5 || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pos: idx=%0d valid=%b want 5/1", sc_idx, out_valid); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({busy, err, out_valid, done, sc_idx, sel, ramp_re, ramp_im} !== '0) begin n_fail++; $display("FAIL mid_reset: got %h want 0", {busy, err, out_valid, done, sc_idx, sel, ramp_re, ramp_im}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle: busy=%b valid=%b want 0/0", busy, out_valid); end
  endtask

  task automatic test_im_independent;
    do_start(0, 4096, -4096, 5632, -5632);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      n_chk++; if (out_valid !== 1'b1 || ramp_re !== 16'(4096 + 256 * k) || ramp_im !== 16'(-4096 - 256 * k)) begin n_fail++; $display("FAIL im_value k=%0d: got %0d/%0d want %0d/%0d", k, ramp_re, ramp_im, 4096 + 256 * k, -4096 - 256 * k); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    nshift = '0;
    {est1_re, est1_im, est2_re, est2_im} = '0;
    @(negedge clk);
    test_reset;
    test_ramp_re;
    test_neg_slope;
    test_saturation;
    test_illegal;
    test_back_to_back;
    test_midrun_reset;
    test_im_independent;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/interp_ramp_seq.md
# interp_ramp_seq

Sequential linear-interpolation engine feeding the channel-estimate selection mux (`mux_h1`) in the NB-IoT channel estimation chain.
- Takes two pilot-derived estimates, `est1` at subcarrier k1 = `nshift` and `est2` at k2 = k1+6.
- Walks all 12 subcarriers of the PRB. For each subcarrier it emits one interpolated or extrapolated complex value and the matching 2-bit mux select.
- The integrating level wires `ramp_*` to both `div_res_1` and `div_res_2` of the mux, and `est*` straight through.

## Interface
Parameters:
- WIDTH, 16, signed Q1.15 width of each real/imag component
- GUARD, 4, extra accumulator bits for extrapolation headroom

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- nshift  in  3  pilot offset k1; legal 0..5
- est1_re, est1_im  in  WIDTH  signed estimate at k1
- est2_re, est2_im  in  WIDTH  signed estimate at k2
- busy  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse: start rejected because nshift > 5
- out_valid  out  1  high for each emitted subcarrier
- sc_idx  out  4  subcarrier index 0..11 of current output
- sel  out  2  mux select: 00 at k1, 10 at k2, 01 for k1<k<k2, 11 for k<k1 or k>k2
- ramp_re, ramp_im  out  WIDTH  saturated ramp value for sc_idx
- done  out  1  pulse coincident with sc_idx=11

## Operation
- **Reset value of all outputs:** every output is 0 after `rst`. `rst` mid-operation forces IDLE on the next edge and discards latched data.
- **Start acceptance:**
  - In IDLE, `start` latches `est1_*`, `est2_*` and `nshift`.
  - If `nshift` > 5, `err` pulses, the block stays IDLE and the latched data is not used.
  - `start` while busy is ignored. This includes `start` on the cycle `done` is high.
- **FSM:** IDLE → STEP → BASE → RUN → IDLE.
  - **STEP (1 cycle), per component:**
    - delta = est2 − est1, (WIDTH+1)-bit signed.
    - step = (delta × 5461 + 2^14) >>> 15, an arithmetic shift. This is rounded delta/6.
  - **BASE (k1 cycles; skipped if k1 = 0):**
    - The accumulator is loaded with est1 sign-extended to WIDTH+GUARD bits.
    - One step is subtracted per cycle, so the accumulator ends at est1 − k1·step.
  - **RUN (12 cycles):**
    - Emit the current accumulator value, then add step.
    - `sc_idx` runs 0..11 and `sel` is decoded from `sc_idx` versus k1/k2.
- **Output saturation:** the accumulator is never saturated internally. The value driven on `ramp_*` is saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- **Values at pilot positions:** at k1 and k2 `ramp_*` still carry the accumulator value. The mux ignores it because `sel` selects `est1`/`est2` there.

## Timing
- Edge t samples `start`. STEP occupies t+1. BASE occupies t+2..t+1+k1.
- `out_valid` is high on cycles t+2+k1 .. t+13+k1. All outputs are registered.
- Latency from `start` to first output is 2+k1 cycles. Total busy time is 13+k1 cycles.
- `busy` rises at t+1 and falls the cycle after `done`.
- The earliest re-start is accepted at the edge following the fall of `busy`.
- `err` is high at t+1 for a rejected start.
- Outside RUN: `out_valid`, `done` and `sel` are 0; `sc_idx` and `ramp_*` hold their last values.

## Structure
- **Package `interp_pkg`:** FSM state enum; INV6_Q15 = 5461; NUM_SC = 12; PILOT_SPACING = 6; ROUND_Q15 = 16384; select encodings SEL_EST1 = 00, SEL_INT = 01, SEL_EST2 = 10, SEL_EXT = 11.
- **Sub-module `interp_step_calc`:** a purely combinational subtract-multiply-round for one component. It is instantiated twice (re, im), and its outputs are registered in STEP by the parent.

## Test plan
- **Interior/exterior ramp, re path:** `est1_re` = 4096, `est2_re` = 5632, `nshift` = 0. Required response:
  - step = 256.
  - `ramp_re` = 4096 + 256·k for k = 0..11, ending at 6912.
  - `sel` = 00, 01×5, 10, 11×5.
  - First `out_valid` 2 cycles after `start`.
- **Negative slope with left extrapolation:** `est1` = 0, `est2` = −600, `nshift` = 3. Required response:
  - step = −100, with 3 BASE cycles.
  - k=0 `ramp` = 300 with `sel` 11; k=3 `sel` 00; k=9 `sel` 10; k=11 `ramp` = −800.
  - First `out_valid` 5 cycles after `start`.
- **Saturation:** `est1_re` = 28672, `est2_re` = 32767, `nshift` = 0. Required response:
  - step = 682.
  - `ramp_re` = 32767 for k ≥ 7; k=6 accumulator 32764, passed through unsaturated.
- **Illegal shift:** `start` with `nshift` = 6. Required response:
  - `err` pulses one cycle.
  - `busy` stays 0 and `out_valid` never asserts.
- **Start during busy and mid-run reset:**
  - `start` at `done` is ignored; the next `start` one cycle after `busy` falls runs normally.
  - `rst` at sc_idx = 5 zeroes all outputs next cycle and returns the FSM to IDLE.
- **Independent re/im paths:** `est1` = (4096, −4096), `est2` = (5632, −5632). Required response: `ramp_im` = −`ramp_re` on every valid cycle.
